// File: rtl/morse_sequencer.sv
// Queued A-Z Morse sequencer: letter FIFO, pattern ROM, and a unit-timed tone
// waveform with automatic letter/word gaps, abort and completion pulses.
module morse_sequencer #(
    parameter int CLOCK_FREQUENCY = 500,
    parameter int UNIT_TICKS      = CLOCK_FREQUENCY / 2,
    parameter int FIFO_DEPTH      = 4,
    parameter int LETTER_GAP      = 3,
    parameter int WORD_GAP        = 7
) (
    input  logic       ClockIn,
    input  logic       ResetN,
    input  logic       LetterValid,
    input  logic [4:0] Letter,
    output logic       LetterReady,
    input  logic       Abort,
    output logic       DotDashOut,
    output logic       NewBitOut,
    output logic       Busy,
    output logic       Done,
    output logic       Error
);
    localparam int TW   = $clog2(UNIT_TICKS + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int MAXU = (WORD_GAP > 13) ? ((WORD_GAP > LETTER_GAP) ? WORD_GAP : LETTER_GAP)
                                          : ((LETTER_GAP > 13) ? LETTER_GAP : 13);
    localparam int UW   = $clog2(MAXU + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(UNIT_TICKS - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SYMBOL, S_GAP} state_t;

    // Element list per letter: {count, elements with the first at bit 3, 1 = dash}.
    // Expanded to a left-aligned unit pattern plus its length in units.
    function automatic logic [16:0] rom_lookup(input logic [4:0] code);
        logic [2:0]  n;
        logic [3:0]  el;
        logic [12:0] acc;
        logic [3:0]  len;
        case (code)
            5'd0:  {n, el} = {3'd2, 4'b0100};
            5'd1:  {n, el} = {3'd4, 4'b1000};
            5'd2:  {n, el} = {3'd4, 4'b1010};
            5'd3:  {n, el} = {3'd3, 4'b1000};
            5'd4:  {n, el} = {3'd1, 4'b0000};
            5'd5:  {n, el} = {3'd4, 4'b0010};
            5'd6:  {n, el} = {3'd3, 4'b1100};
            5'd7:  {n, el} = {3'd4, 4'b0000};
            5'd8:  {n, el} = {3'd2, 4'b0000};
            5'd9:  {n, el} = {3'd4, 4'b0111};
            5'd10: {n, el} = {3'd3, 4'b1010};
            5'd11: {n, el} = {3'd4, 4'b0100};
            5'd12: {n, el} = {3'd2, 4'b1100};
            5'd13: {n, el} = {3'd2, 4'b1000};
            5'd14: {n, el} = {3'd3, 4'b1110};
            5'd15: {n, el} = {3'd4, 4'b0110};
            5'd16: {n, el} = {3'd4, 4'b1101};
            5'd17: {n, el} = {3'd3, 4'b0100};
            5'd18: {n, el} = {3'd3, 4'b0000};
            5'd19: {n, el} = {3'd1, 4'b1000};
            5'd20: {n, el} = {3'd3, 4'b0010};
            5'd21: {n, el} = {3'd4, 4'b0001};
            5'd22: {n, el} = {3'd3, 4'b0110};
            5'd23: {n, el} = {3'd4, 4'b1001};
            5'd24: {n, el} = {3'd4, 4'b1011};
            5'd25: {n, el} = {3'd4, 4'b1100};
            default: {n, el} = 7'd0;
        endcase
        acc = '0;
        len = '0;
        for (int k = 0; k < 4; k++) begin
            if (k < int'(n)) begin
                if (k != 0) begin
                    acc = {acc[11:0], 1'b0};
                    len = len + 4'd1;
                end
                if (el[2'(3 - k)]) begin
                    acc = {acc[9:0], 3'b111};
                    len = len + 4'd3;
                end else begin
                    acc = {acc[11:0], 1'b1};
                    len = len + 4'd1;
                end
            end
        end
        return {acc << (4'd13 - len), len};
    endfunction

    state_t          r_state, w_state_nxt;
    logic [TW-1:0]   r_tick;
    logic [UW-1:0]   r_units;
    logic [12:0]     r_shift;
    logic [4:0]      r_fifo [FIFO_DEPTH];
    logic [AW-1:0]   r_wr, r_rd;
    logic [CW-1:0]   r_cnt;

    logic            w_full, w_empty, w_push, w_pop, w_unit_end, w_last_unit;
    logic [4:0]      w_head;
    logic [12:0]     w_pat;
    logic [3:0]      w_len;

    assign w_full      = (r_cnt == CW'(FIFO_DEPTH));
    assign w_empty     = (r_cnt == '0);
    // Held low while in reset so the host never sees a ready it cannot use.
    assign LetterReady = ResetN & ~w_full;
    assign w_push      = LetterValid & LetterReady & ~Abort;
    assign w_pop       = (r_state == S_LOAD);
    assign w_head      = r_fifo[r_rd];
    assign {w_pat, w_len} = rom_lookup(w_head);
    assign w_unit_end  = (r_state == S_SYMBOL || r_state == S_GAP) && (r_tick == TICK_LAST);
    assign w_last_unit = (r_units == UW'(1));

    always_ff @(posedge ClockIn) begin
        if (w_push) r_fifo[r_wr] <= Letter;
    end

    always_ff @(posedge ClockIn or negedge ResetN) begin
        if (!ResetN) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (Abort) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge ClockIn or negedge ResetN) begin
        if (!ResetN) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (!w_empty || w_push) w_state_nxt = S_LOAD;
            S_LOAD: begin
                if (w_head < 5'd26)       w_state_nxt = S_SYMBOL;
                else if (w_head == 5'd26) w_state_nxt = S_GAP;
                else if (r_cnt > CW'(1) || w_push) w_state_nxt = S_LOAD;
                else                      w_state_nxt = S_IDLE;
            end
            S_SYMBOL: if (w_unit_end && w_last_unit) w_state_nxt = S_GAP;
            S_GAP:    if (w_unit_end && w_last_unit) w_state_nxt = w_empty ? S_IDLE : S_LOAD;
            default:  w_state_nxt = S_IDLE;
        endcase
        if (Abort) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge ClockIn or negedge ResetN) begin
        if (!ResetN) begin
            r_tick  <= '0;
            r_units <= '0;
            r_shift <= '0;
        end else if (Abort) begin
            r_tick <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_tick  <= '0;
                    r_shift <= w_pat;
                    r_units <= (w_head == 5'd26) ? UW'(WORD_GAP) : UW'(w_len);
                end
                S_SYMBOL, S_GAP: begin
                    if (w_unit_end) begin
                        r_tick <= '0;
                        if (w_last_unit) begin
                            if (r_state == S_SYMBOL) r_units <= UW'(LETTER_GAP);
                        end else begin
                            r_units <= r_units - UW'(1);
                            r_shift <= {r_shift[11:0], 1'b0};
                        end
                    end else begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign DotDashOut = (r_state == S_SYMBOL) & r_shift[12];
    assign NewBitOut  = (r_state == S_SYMBOL || r_state == S_GAP) && (r_tick == '0);
    assign Busy       = (r_state != S_IDLE) || !w_empty;
    assign Done       = (r_state == S_GAP) && w_unit_end && w_last_unit && w_empty && !Abort;
    assign Error      = (r_state == S_LOAD) && (w_head > 5'd26);
endmodule

// File: tb/tb_morse_sequencer.sv
// Bench for morse_sequencer: a letter-level Morse model expanded into per-cycle
// expectations, compared every cycle, plus hand-computed timing pins per scenario.
module tb_morse_sequencer;
    localparam int UT = 4, DEPTH = 4, LG = 3, WG = 7;

    logic       ClockIn = 0, ResetN = 0, LetterValid = 0, Abort = 0;
    logic [4:0] Letter = '0;
    logic       LetterReady, DotDashOut, NewBitOut, Busy, Done, Error;
    int         total = 0, bad = 0, cyc = 0;

    morse_sequencer #(.CLOCK_FREQUENCY(8), .UNIT_TICKS(UT), .FIFO_DEPTH(DEPTH),
                      .LETTER_GAP(LG), .WORD_GAP(WG)) dut (
        .ClockIn(ClockIn), .ResetN(ResetN), .LetterValid(LetterValid), .Letter(Letter),
        .LetterReady(LetterReady), .Abort(Abort), .DotDashOut(DotDashOut),
        .NewBitOut(NewBitOut), .Busy(Busy), .Done(Done), .Error(Error));

    always #5 ClockIn = ~ClockIn;
    always @(posedge ClockIn) cyc <= cyc + 1;

    typedef struct packed { bit dd; bit nb; bit eog; bit load; } rec_t;
    rec_t stream[$];
    int   mq[$];
    int   nb_cyc[$], done_cyc[$], err_cyc[$];
    bit   dd_units[$];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, act, exp);
        end
    endtask

    function automatic string morse(input int c);
        case (c)
            0: return ".-";    1: return "-...";  2: return "-.-.";  3: return "-..";
            4: return ".";     5: return "..-.";  6: return "--.";   7: return "....";
            8: return "..";    9: return ".---"; 10: return "-.-";  11: return ".-..";
           12: return "--";   13: return "-.";   14: return "---";  15: return ".--.";
           16: return "--.-"; 17: return ".-.";  18: return "...";  19: return "-";
           20: return "..-";  21: return "...-"; 22: return ".--";  23: return "-..-";
           24: return "-.--"; 25: return "--..";
           default: return "";
        endcase
    endfunction

    function automatic void add_unit(input bit v, input bit eog);
        rec_t r;
        for (int t = 0; t < UT; t++) begin
            r.dd = v; r.nb = (t == 0); r.eog = eog && (t == UT - 1); r.load = 1'b0;
            stream.push_back(r);
        end
    endfunction

    function automatic void build(input int c);
        string s;
        if (c == 26) begin
            for (int u = 0; u < WG; u++) add_unit(1'b0, u == WG - 1);
        end else begin
            s = morse(c);
            for (int i = 0; i < s.len(); i++) begin
                if (i > 0) add_unit(1'b0, 1'b0);
                if (s[i] == "-") repeat (3) add_unit(1'b1, 1'b0);
                else add_unit(1'b1, 1'b0);
            end
            for (int u = 0; u < LG; u++) add_unit(1'b0, u == LG - 1);
        end
    endfunction

    function automatic rec_t load_rec();
        rec_t r;
        r = '0; r.load = 1'b1;
        return r;
    endfunction

    // Per-cycle compare against the model, then advance the model with this cycle's inputs.
    always @(negedge ClockIn) begin
        rec_t r;
        bit   push, e_done, e_err, e_busy, e_rdy;
        int   c;
        if (!ResetN) begin
            stream.delete(); mq.delete();
            chk("rst_dd", DotDashOut, 0); chk("rst_nb", NewBitOut, 0);
            chk("rst_busy", Busy, 0);     chk("rst_done", Done, 0);
            chk("rst_err", Error, 0);     chk("rst_ready", LetterReady, 0);
        end else begin
            r      = (stream.size() > 0) ? stream[0] : '0;
            e_done = r.eog && (mq.size() == 0) && !Abort;
            e_err  = r.load && (mq.size() > 0) && (mq[0] > 26);
            e_busy = (stream.size() > 0) || (mq.size() > 0);
            e_rdy  = (mq.size() < DEPTH);
            chk("dd", DotDashOut, r.dd); chk("nb", NewBitOut, r.nb);
            chk("done", Done, e_done);   chk("err", Error, e_err);
            chk("busy", Busy, e_busy);   chk("ready", LetterReady, e_rdy);
            if (NewBitOut) begin nb_cyc.push_back(cyc); dd_units.push_back(DotDashOut); end
            if (Done) done_cyc.push_back(cyc);
            if (Error) err_cyc.push_back(cyc);
            push = LetterValid && e_rdy && !Abort;
            if (Abort) begin
                stream.delete(); mq.delete();
            end else begin
                if (stream.size() > 0) begin
                    void'(stream.pop_front());
                    if (r.load && mq.size() > 0) begin
                        c = mq.pop_front();
                        if (c <= 26) build(c);
                        else if (mq.size() > 0 || push) stream.push_back(load_rec());
                    end else if (r.eog && mq.size() > 0) begin
                        stream.push_back(load_rec());
                    end
                end else if (mq.size() > 0 || push) begin
                    stream.push_back(load_rec());
                end
                if (push) mq.push_back(int'(Letter));
            end
        end
    end

    task automatic sync();
        @(posedge ClockIn); #1;
    endtask

    task automatic clear_logs();
        nb_cyc.delete(); done_cyc.delete(); err_cyc.delete(); dd_units.delete();
    endtask

    // Offer a code until accepted; returns one cycle later at posedge+1 with valid still high.
    task automatic offer(input int code, output int acc);
        int n;
        LetterValid = 1'b1; Letter = 5'(code); n = 0;
        @(negedge ClockIn);
        while (!LetterReady && n < 500) begin @(negedge ClockIn); n++; end
        chk("offer_accept", LetterReady, 1);
        acc = cyc;
        sync();
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        @(negedge ClockIn);
        while (Busy && n < lim) begin @(negedge ClockIn); n++; end
        chk("idle_reached", Busy, 0);
        sync();
    endtask

    task automatic run_single_e(input string tag);
        int t0;
        clear_logs(); sync();
        offer(4, t0); LetterValid = 1'b0;
        wait_idle(200);
        chk({tag, "_nb_count"}, nb_cyc.size(), 4);
        if (nb_cyc.size() == 4) begin
            chk({tag, "_nb0"}, nb_cyc[0] - t0, 2);  chk({tag, "_nb1"}, nb_cyc[1] - t0, 6);
            chk({tag, "_nb2"}, nb_cyc[2] - t0, 10); chk({tag, "_nb3"}, nb_cyc[3] - t0, 14);
            chk({tag, "_u0"}, dd_units[0], 1);      chk({tag, "_u1"}, dd_units[1], 0);
        end
        chk({tag, "_done_count"}, done_cyc.size(), 1);
        if (done_cyc.size() == 1) chk({tag, "_done_at"}, done_cyc[0] - t0, 17);
    endtask

    initial begin
        int acc[6];
        int a, k, n;
        logic [15:0] an_units;
        #2 chk("in_reset_ready", LetterReady, 0);
        repeat (3) @(posedge ClockIn);
        #1 ResetN = 1'b1;
        @(negedge ClockIn);
        chk("post_rst_ready", LetterReady, 1); chk("post_rst_busy", Busy, 0);

        run_single_e("e1");

        // A then N back to back
        clear_logs(); sync();
        offer(0, a); offer(13, a); LetterValid = 1'b0;
        wait_idle(300);
        chk("an_nb_count", nb_cyc.size(), 16);
        chk("an_done_count", done_cyc.size(), 1);
        an_units = 16'b1011_1000_1110_1000;
        if (dd_units.size() == 16)
            for (int i = 0; i < 16; i++) chk("an_unit", dd_units[i], an_units[15 - i]);

        // FIFO fill with G while the first G is emitting
        clear_logs(); sync();
        for (int i = 0; i < 6; i++) offer(6, acc[i]);
        LetterValid = 1'b0;
        chk("full_first5", acc[4] - acc[0], 4);
        chk("full_sixth", acc[5] - acc[0], 51);
        wait_idle(1000);
        chk("full_done_count", done_cyc.size(), 1);

        // E, word space, illegal, E
        clear_logs(); sync();
        offer(4, a); offer(26, a); offer(30, a); offer(4, a); LetterValid = 1'b0;
        wait_idle(500);
        chk("sp_err_count", err_cyc.size(), 1);
        chk("sp_nb_count", nb_cyc.size(), 15);
        chk("sp_done_count", done_cyc.size(), 1);

        // Abort in the middle of the second T's dash
        clear_logs(); sync();
        offer(19, a); offer(19, a); offer(19, a); LetterValid = 1'b0;
        n = 0;
        while (nb_cyc.size() < 7 && n < 200) begin @(negedge ClockIn); n++; end
        chk("abort_reach", (nb_cyc.size() >= 7) ? 1 : 0, 1);
        repeat (5) @(posedge ClockIn);
        #1 Abort = 1'b1; LetterValid = 1'b1; Letter = 5'd4;
        sync(); Abort = 1'b0; LetterValid = 1'b0;
        k = nb_cyc.size();
        @(negedge ClockIn);
        chk("abort_dd", DotDashOut, 0); chk("abort_busy", Busy, 0);
        chk("abort_ready", LetterReady, 1);
        repeat (60) @(negedge ClockIn);
        chk("abort_no_done", done_cyc.size(), 0);
        chk("abort_no_nb", nb_cyc.size(), k);

        // Async reset between edges while a dot is on
        clear_logs(); sync();
        offer(4, a); LetterValid = 1'b0;
        repeat (2) @(posedge ClockIn);
        #3 chk("pre_rst_dd", DotDashOut, 1);
        ResetN = 1'b0;
        #1;
        chk("arst_dd", DotDashOut, 0); chk("arst_nb", NewBitOut, 0);
        chk("arst_busy", Busy, 0);     chk("arst_done", Done, 0);
        chk("arst_err", Error, 0);     chk("arst_ready", LetterReady, 0);
        repeat (2) @(posedge ClockIn);
        #1 ResetN = 1'b1;
        run_single_e("e2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        bad++;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/morse_sequencer.md
Name: morse_sequencer

Overview:
- Parametrised successor to the single-letter 3-bit Morse encoder.
- Covers the full A–Z alphabet plus a word-space code, using variable-length patterns held in an internal ROM.
- A small letter FIFO with a valid/ready handshake lets a host queue text.
- Emits a unit-timed DotDashOut waveform for the LED/buzzer path, with automatic inter-letter and inter-word gaps, abort, and completion signalling.

Parameters:
- CLOCK_FREQUENCY, 500, input clock rate in Hz.
- UNIT_TICKS, CLOCK_FREQUENCY/2, clock cycles per Morse unit (0.5 s at default); minimum 2.
- FIFO_DEPTH, 4, letter queue entries; power of two, ≥2.
- LETTER_GAP, 3, zero units appended after every letter.
- WORD_GAP, 7, zero units emitted for the space code.

Ports:
- ClockIn  in  1  system clock.
- ResetN  in  1  asynchronous, active-low reset.
- LetterValid  in  1  host offers Letter this cycle.
- Letter  in  5  0–25 = A–Z, 26 = word space, 27–31 illegal.
- LetterReady  out  1  FIFO can accept; push occurs when LetterValid & LetterReady.
- Abort  in  1  synchronous flush of FIFO and current symbol.
- DotDashOut  out  1  Morse waveform (1 = tone on).
- NewBitOut  out  1  one-cycle pulse at the start of every unit.
- Busy  out  1  high while not IDLE or FIFO non-empty.
- Done  out  1  one-cycle pulse when the last queued unit completes.
- Error  out  1  one-cycle pulse when an illegal code is accepted.

Behaviour:
- **Reset (ResetN low, async):**
  - FIFO empty; FSM IDLE; unit counter 0.
  - DotDashOut=0, NewBitOut=0, Busy=0, Done=0, Error=0, LetterReady=1 (asserted on release).
- **Encoding:**
  - Dot = 1 unit of 1; dash = 3 units of 1; single 0 unit between elements; no trailing 0 in the ROM.
  - ROM entry: 13-bit pattern (MSB first) + 4-bit length. Longest letters (J, Q, Y) = 13 units; E = 1 unit.
  - Letter is followed by LETTER_GAP zero units. Space code emits WORD_GAP zero units and no letter gap.
- **FIFO:**
  - LetterReady = !full; a push when full is ignored.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Illegal codes are accepted, then discarded at pop: Error pulses in the LOAD cycle and nothing is emitted.
- **FSM states:**
  - IDLE: if FIFO non-empty, go to LOAD.
  - LOAD (1 cycle): pop, fetch ROM, DotDashOut=0. Go to SYMBOL for a letter, GAP for space, or back through IDLE rules if illegal (next LOAD if FIFO non-empty, else IDLE).
  - SYMBOL: shift out the pattern, one bit per unit.
  - GAP: emit the zero units.
  - At the end of GAP: LOAD if FIFO non-empty; otherwise IDLE with Done pulsing that same cycle.
- **Unit timing:**
  - NewBitOut pulses and DotDashOut takes the new unit value in the same cycle.
  - DotDashOut holds for exactly UNIT_TICKS cycles.
  - Latency: push at cycle t into an empty, idle block → LOAD at t+1 → first unit (NewBitOut=1) at t+2.
  - Between queued letters there is exactly one LOAD cycle with DotDashOut=0, in addition to the gap units.
- **Abort** (highest priority below reset):
  - Next cycle: FIFO empty, IDLE, DotDashOut=0; no Done and no NewBitOut.
  - A push in the same cycle as Abort is dropped.
- **Busy** = (state≠IDLE) | !empty.
- Counters use minimal widths ($clog2 of the respective maximum + 1); no wrap is reachable in legal operation.

Test Plan (UNIT_TICKS=4, FIFO_DEPTH=4):
1. **Single E:** push Letter=4 at t0 → NewBitOut pulses at t0+2, +6, +10, +14. DotDashOut is 1 for cycles t0+2..t0+5 and 0 through the 3 gap units. Done pulses at t0+17, then Busy=0.
2. **Back-to-back A,N:** push 0 then 13 on consecutive cycles.
   - DotDashOut unit sequence: 1,0,1,1,1,0,0,0 | LOAD | 1,1,1,0,1,0,0,0.
   - 16 NewBitOut pulses in total and exactly one Done.
3. **FIFO full:** hold LetterValid with codes 6,6,6,6,6,6 while the first letter is emitting.
   - LetterReady drops after 5 accepts (1 popped + 4 queued).
   - The 6th offer is held off until the next LOAD, then accepted.
4. **Space and illegal:** push 4, 26, 30, 4.
   - Output: E, 3-unit letter gap, 7 zero units, E.
   - Error pulses once at the LOAD of code 30.
5. **Abort:** assert Abort mid-dash of the 2nd of 3 queued letters → next cycle DotDashOut=0, Busy=0, LetterReady=1; no Done.
6. **Async reset:** drop ResetN mid-unit, between clock edges → all outputs 0 immediately. After release, a push of Letter=4 behaves exactly as in scenario 1.
